lpddr2_mem_arbiter: RTL and testbench

Two-port request arbiter that sits directly upstream of the LPDDR2 memory controller FSM and feeds its `read_req`/`write_req`/`addr`/`inData` inputs. It merges the CPU instruction-fetch port and the load/store data port into one serialized stream of single-word accesses. It tracks completion from the controller's exported state, and returns read data with a one-cycle acknowledge per request.

---
 rtl/lpddr2_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_lpddr2_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpddr2_mem_arbiter.sv
// Serializes the CPU fetch port and load/store port into single-word LPDDR2 controller requests.
// Define IFETCH_BUFFER_EN to add a one-entry fetch buffer that short-circuits repeated fetches.
module lpddr2_mem_arbiter #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_read_req,
    output logic              mem_write_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [3:0]        mem_state,
    output logic              busy
);
    localparam logic [3:0] MEM_IDLE = 4'd1;

    typedef enum logic [2:0] {
        ST_WAIT_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_data_q, gnt_data_d;
    logic              xfer_rd_q, xfer_rd_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              busy_q, busy_d;
    logic              fetch_hit;
    logic [DATA_W-1:0] fetch_buf_data;
    logic              mem_done;

    assign mem_done = (state_q == ST_WAIT) && (mem_state == MEM_IDLE);

`ifdef IFETCH_BUFFER_EN
    logic [ADDR_W-1:0] buf_tag_q, buf_tag_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic              buf_vld_q, buf_vld_d;

    // Refill on every completed fetch; a store to the buffered word invalidates it.
    always_comb begin
        buf_tag_d  = buf_tag_q;
        buf_data_d = buf_data_q;
        buf_vld_d  = buf_vld_q;
        if (mem_done) begin
            if (!gnt_data_q) begin
                buf_tag_d  = addr_q;
                buf_data_d = mem_rdata;
                buf_vld_d  = 1'b1;
            end else if (!xfer_rd_q && (addr_q == buf_tag_q)) begin
                buf_vld_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            buf_tag_q  <= '0;
            buf_data_q <= '0;
            buf_vld_q  <= 1'b0;
        end else begin
            buf_tag_q  <= buf_tag_d;
            buf_data_q <= buf_data_d;
            buf_vld_q  <= buf_vld_d;
        end
    end

    assign fetch_hit      = buf_vld_q && (if_addr == buf_tag_q);
    assign fetch_buf_data = buf_data_q;
`else
    assign fetch_hit      = 1'b0;
    assign fetch_buf_data = '0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_data_d = gnt_data_q;
        xfer_rd_d  = xfer_rd_q;
        rd_req_d   = rd_req_q;
        wr_req_d   = wr_req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        case (state_q)
            ST_WAIT_INIT: if (mem_state == MEM_IDLE) state_d = ST_IDLE;
            ST_IDLE: begin
                if (d_rd || d_wr) begin
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    rd_req_d   = d_rd;
                    wr_req_d   = !d_rd;
                    xfer_rd_d  = d_rd;
                    gnt_data_d = 1'b1;
                    state_d    = ST_ISSUE;
                end else if (if_req) begin
                    if (fetch_hit) begin
                        if_rdata_d = fetch_buf_data;
                        if_ack_d   = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        addr_d     = if_addr;
                        rd_req_d   = 1'b1;
                        xfer_rd_d  = 1'b1;
                        gnt_data_d = 1'b0;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            // Drop the strobe as soon as the controller has left IDLE so it cannot re-issue.
            ST_ISSUE: begin
                if (mem_state != MEM_IDLE) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_state == MEM_IDLE) begin
                    if (xfer_rd_q && gnt_data_q)  d_rdata_d  = mem_rdata;
                    if (xfer_rd_q && !gnt_data_q) if_rdata_d = mem_rdata;
                    if_ack_d = !gnt_data_q;
                    d_ack_d  = gnt_data_q;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_WAIT_INIT;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= ST_WAIT_INIT;
            gnt_data_q <= 1'b0;
            xfer_rd_q  <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_data_q <= gnt_data_d;
            xfer_rd_q  <= xfer_rd_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign if_rdata      = if_rdata_q;
    assign if_ack        = if_ack_q;
    assign d_rdata       = d_rdata_q;
    assign d_ack         = d_ack_q;
    assign mem_read_req  = rd_req_q;
    assign mem_write_req = wr_req_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_lpddr2_mem_arbiter.sv
// Bench for lpddr2_mem_arbiter: behavioural LPDDR2 controller, word memory model and per-cycle checker.
module tb_lpddr2_mem_arbiter;
    localparam int AW = 27;
    localparam int DW = 32;

    logic          iCLK = 1'b0;
    logic          iRST_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_rd = 1'b0;
    logic          d_wr = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_read_req, mem_write_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [3:0]    mem_state;
    logic          busy;

    lpddr2_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_state(mem_state), .busy(busy)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word memory shared by the controller model and the checker.
    logic [DW-1:0] ref_mem [int];
    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction
    function automatic void mem_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ref_mem[int'(a)] = d;
    endfunction

    // Controller: INIT=0, IDLE=1, READ=2, WRITE=3; busy for ctl_lat cycles per access.
    logic [3:0]    ctl_st;
    int            ctl_cnt;
    int            ctl_lat = 4;
    bit            ctl_init_done = 1'b0;
    logic [AW-1:0] ctl_addr;
    logic          acc_wr[$];
    logic [AW-1:0] acc_addr[$];

    assign mem_state = ctl_st;

    always @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ctl_st   <= 4'd0;
            ctl_cnt  <= 0;
            ctl_addr <= '0;
        end else begin
            case (ctl_st)
                4'd0: if (ctl_init_done) ctl_st <= 4'd1;
                4'd1: if (mem_read_req || mem_write_req) begin
                    ctl_st   <= mem_read_req ? 4'd2 : 4'd3;
                    ctl_cnt  <= ctl_lat - 1;
                    ctl_addr <= mem_addr;
                    acc_wr.push_back(!mem_read_req);
                    acc_addr.push_back(mem_addr);
                end
                default: if (ctl_cnt == 0) begin
                    ctl_st <= 4'd1;
                    if (ctl_st == 4'd2) mem_rdata <= mem_rd(mem_addr);
                    else mem_wr(mem_addr, mem_wdata);
                end else begin
                    ctl_cnt <= ctl_cnt - 1;
                end
            endcase
        end
    end

    // Per-cycle protocol and data checks.
    int            run = 0;
    int            last_run = 0;
    int            n_iack = 0;
    int            n_dack = 0;
    logic          prev_iack = 1'b0, prev_dack = 1'b0;
    logic [DW-1:0] last_if = '0, last_d = '0;

    always @(negedge iCLK) begin
        if (!iRST_n) begin
            run       <= 0;
            prev_iack <= 1'b0;
            prev_dack <= 1'b0;
            last_if   <= '0;
            last_d    <= '0;
        end else begin
            chk("strobe_excl", 64'(mem_read_req & mem_write_req), 0);
            if (mem_read_req || mem_write_req) begin
                run <= run + 1;
            end else if (run != 0) begin
                chk("strobe_len", 64'(run), 2);
                last_run <= run;
                run      <= 0;
            end
            if (ctl_st == 4'd2 || ctl_st == 4'd3) chk("addr_hold", 64'(mem_addr), 64'(ctl_addr));
            if (if_ack) begin
                chk("if_ack_req", 64'(if_req), 1);
                chk("if_ack_pulse", 64'(prev_iack), 0);
                chk("if_rdata", 64'(if_rdata), 64'(mem_rd(if_addr)));
                last_if <= if_rdata;
                n_iack  <= n_iack + 1;
            end else begin
                chk("if_rdata_hold", 64'(if_rdata), 64'(last_if));
            end
            if (d_ack) begin
                chk("d_ack_req", 64'(d_rd | d_wr), 1);
                chk("d_ack_pulse", 64'(prev_dack), 0);
                if (d_rd) chk("d_rdata", 64'(d_rdata), 64'(mem_rd(d_addr)));
                else      chk("d_store", 64'(mem_rd(d_addr)), 64'(d_wdata));
                n_dack <= n_dack + 1;
            end
            if (d_ack && d_rd) last_d <= d_rdata;
            else if (!d_ack) chk("d_rdata_hold", 64'(d_rdata), 64'(last_d));
            prev_iack <= if_ack;
            prev_dack <= d_ack;
        end
    end

    task automatic wait_ack(input bit want_if, output int cyc);
        cyc = 0;
        forever begin
            @(posedge iCLK); #1;
            cyc++;
            if (want_if ? if_ack : d_ack) break;
            if (cyc >= 200) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout: no %s ack after %0d cycles", want_if ? "if" : "d", cyc);
                break;
            end
        end
        @(negedge iCLK); #1;
    endtask

    task automatic do_fetch(input logic [AW-1:0] a, output int cyc);
        @(negedge iCLK); #1;
        if_addr = a;
        if_req  = 1'b1;
        wait_ack(1'b1, cyc);
        if_req  = 1'b0;
    endtask

    task automatic do_data(input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, output int cyc);
        @(negedge iCLK); #1;
        d_addr  = a;
        d_wdata = wd;
        d_rd    = rd;
        d_wr    = wr;
        wait_ack(1'b0, cyc);
        d_rd    = 1'b0;
        d_wr    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_strobes"}, 64'({mem_read_req, mem_write_req, if_ack, d_ack}), 0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
        chk({tag, "_if_rdata"}, 64'(if_rdata), 0);
        chk({tag, "_d_rdata"}, 64'(d_rdata), 0);
    endtask

    initial begin
        int cyc, n0, i0, d0, bcnt;
        mem_wr(27'h100, 32'hDEADBEEF);
        mem_wr(27'h040, 32'hCAFEF00D);

        // Reset and controller init
        repeat (3) @(posedge iCLK);
        #1 chk_all_zero("rst");
        @(negedge iCLK) iRST_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge iCLK); #1;
            chk("init_busy", 64'(busy), 1);
            chk("init_out", 64'({mem_read_req, mem_write_req, if_ack, d_ack, mem_addr, if_rdata}), 0);
        end
        ctl_init_done = 1'b1;
        @(posedge iCLK); #1;
        chk("busy_before_idle", 64'(busy), 1);
        @(posedge iCLK); #1;
        chk("busy_after_idle", 64'(busy), 0);

        // Fetch 0x100, latency 4 + 3
        n0 = acc_addr.size(); i0 = n_iack;
        do_fetch(27'h100, cyc);
        chk("fetch_lat", 64'(cyc), 7);
        chk("fetch_data", 64'(if_rdata), 64'h0000_0000_DEAD_BEEF);
        chk("fetch_strobe_cycles", 64'(last_run), 2);
        repeat (4) @(posedge iCLK);
        #1;
        chk("fetch_one_ack", 64'(n_iack - i0), 1);
        chk("fetch_one_access", 64'(acc_addr.size() - n0), 1);

        // Simultaneous fetch and store: store first
        n0 = acc_addr.size(); i0 = n_iack;
        @(negedge iCLK); #1;
        if_addr = 27'h100; if_req = 1'b1;
        d_addr = 27'h200; d_wdata = 32'h12345678; d_wr = 1'b1;
        wait_ack(1'b0, cyc);
        d_wr = 1'b0;
        chk("store_before_fetch", 64'(n_iack - i0), 0);
        wait_ack(1'b1, cyc);
        if_req = 1'b0;
        repeat (4) @(posedge iCLK);
        #1;
        chk("store_mem", 64'(mem_rd(27'h200)), 64'h12345678);
        chk("combo_fetch_data", 64'(if_rdata), 64'hDEADBEEF);
`ifdef IFETCH_BUFFER_EN
        chk("combo_accesses", 64'(acc_addr.size() - n0), 1);
`else
        chk("combo_accesses", 64'(acc_addr.size() - n0), 2);
        if (acc_addr.size() >= n0 + 2) begin
            chk("combo_second_rd", 64'(acc_wr[n0+1]), 0);
            chk("combo_second_addr", 64'(acc_addr[n0+1]), 64'h100);
        end
`endif
        if (acc_addr.size() >= n0 + 1) begin
            chk("combo_first_wr", 64'(acc_wr[n0]), 1);
            chk("combo_first_addr", 64'(acc_addr[n0]), 64'h200);
        end

        // Load 0x040 with a 20-cycle controller stall
        ctl_lat = 20;
        n0 = acc_addr.size(); d0 = n_dack;
        do_data(1'b1, 1'b0, 27'h040, 32'h12345678, cyc);
        chk("stall_lat", 64'(cyc), 23);
        chk("stall_data", 64'(d_rdata), 64'hCAFEF00D);
        chk("stall_strobe_cycles", 64'(last_run), 2);
        repeat (4) @(posedge iCLK);
        #1;
        chk("stall_one_ack", 64'(n_dack - d0), 1);
        chk("stall_one_access", 64'(acc_addr.size() - n0), 1);

        // Load and store together: load wins
        ctl_lat = 3;
        n0 = acc_addr.size();
        do_data(1'b1, 1'b1, 27'h040, 32'h0BAD0BAD, cyc);
        chk("prio_data", 64'(d_rdata), 64'hCAFEF00D);
        chk("prio_mem_kept", 64'(mem_rd(27'h040)), 64'hCAFEF00D);
        if (acc_addr.size() >= n0 + 1) chk("prio_is_read", 64'(acc_wr[n0]), 0);
        else chk("prio_access", 64'(acc_addr.size() - n0), 1);

        // Reset while waiting on a load
        ctl_lat = 20;
        d0 = n_dack;
        @(negedge iCLK); #1;
        d_addr = 27'h040; d_wdata = 32'h12345678; d_rd = 1'b1;
        repeat (6) @(posedge iCLK);
        #3;
        ctl_init_done = 1'b0;
        iRST_n = 1'b0;
        #1 chk_all_zero("midrst");
        d_rd = 1'b0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK) iRST_n = 1'b1;
        @(posedge iCLK); #1;
        chk("midrst_wait_init", 64'(busy), 1);
        ctl_init_done = 1'b1;
        ctl_lat = 4;
        bcnt = 0;
        while (busy && bcnt < 20) begin
            @(posedge iCLK); #1;
            bcnt++;
        end
        chk("midrst_back_idle", 64'(busy), 0);
        chk("midrst_no_ack", 64'(n_dack - d0), 0);
        do_fetch(27'h100, cyc);
        chk("recover_lat", 64'(cyc), 7);
        chk("recover_data", 64'(if_rdata), 64'hDEADBEEF);

`ifdef IFETCH_BUFFER_EN
        n0 = acc_addr.size();
        do_fetch(27'h100, cyc);
        chk("buf_hit_lat", 64'(cyc), 1);
        chk("buf_hit_data", 64'(if_rdata), 64'hDEADBEEF);
        chk("buf_hit_no_access", 64'(acc_addr.size() - n0), 0);
        do_data(1'b0, 1'b1, 27'h100, 32'h55AA55AA, cyc);
        n0 = acc_addr.size();
        do_fetch(27'h100, cyc);
        chk("buf_inval_access", 64'(acc_addr.size() - n0), 1);
        chk("buf_inval_data", 64'(if_rdata), 64'h55AA55AA);
`endif

        repeat (3) @(posedge iCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
